// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage sequencer: FSM encoding, default widths
// and the stage-counter width derived from N_LOG.
package ntt_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DW_DEFAULT    = 64;
    localparam int N_LOG_DEFAULT = 3;

    // Stage counter must hold 0..N_LOG-1.
    function automatic int stage_w(input int n_log);
        return (n_log < 2) ? 1 : $clog2(n_log);
    endfunction

endpackage

// File: rtl/ntt_stage_sequencer_addr_gen.sv
// ntt_addr_gen: maps (stage, issue index) to the u/v coefficient addresses and twiddle index.
// Purely combinational, zero latency; no flow control.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N_LOG = N_LOG_DEFAULT,
    parameter int SW    = stage_w(N_LOG)
) (
    input  logic [SW-1:0]    stage,
    input  logic [N_LOG-2:0] j,
    output logic [N_LOG-1:0] u_idx,
    output logic [N_LOG-1:0] v_idx,
    output logic [N_LOG-2:0] tw
);

    localparam int TW_W = N_LOG - 1;
    localparam logic [N_LOG-1:0] ONE = {{(N_LOG-1){1'b0}}, 1'b1};

    logic [N_LOG-1:0] j_ext;
    logic [N_LOG-1:0] half;
    logic [N_LOG-1:0] k;
    int unsigned      sh;

    always_comb begin
        sh    = 32'(stage);
        j_ext = {1'b0, j};
        half  = ONE << sh;
        k     = j_ext & (half - ONE);
        // Insert a zero at bit position s: that bit selects u (0) or v (1).
        u_idx = ((j_ext >> sh) << (sh + 32'd1)) | k;
        v_idx = u_idx | half;
        tw    = TW_W'(k << (N_LOG - 1 - sh));
    end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// In-place radix-2 DIT NTT controller: one butterfly pair per cycle, read-to-write latency 2.
// No backpressure; start is honoured only in IDLE, two drain cycles separate stages.
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int N_LOG = N_LOG_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [N_LOG-1:0] rd_addr_u,
    output logic [N_LOG-1:0] rd_addr_v,
    output logic [N_LOG-2:0] tw_addr,
    input  logic [DW-1:0]    rd_data_u,
    input  logic [DW-1:0]    rd_data_v,
    input  logic [DW-1:0]    tw_data,
    output logic [DW-1:0]    bf_u,
    output logic [DW-1:0]    bf_v,
    output logic [DW-1:0]    bf_w,
    input  logic [DW-1:0]    bf_u_out,
    input  logic [DW-1:0]    bf_v_out,
    output logic             wr_en,
    output logic [N_LOG-1:0] wr_addr_u,
    output logic [N_LOG-1:0] wr_addr_v,
    output logic [DW-1:0]    wr_data_u,
    output logic [DW-1:0]    wr_data_v
);

    localparam int SW = stage_w(N_LOG);
    localparam int JW = N_LOG - 1;
    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG - 1);

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [JW-1:0]    j_q, j_d;
    logic             drain_q, drain_d;

    logic             rd_en_q, rd_en_d;
    logic [N_LOG-1:0] rd_addr_u_q, rd_addr_u_d;
    logic [N_LOG-1:0] rd_addr_v_q, rd_addr_v_d;
    logic [N_LOG-2:0] tw_addr_q, tw_addr_d;

    logic             p1_vld_q, p1_vld_d;
    logic [N_LOG-1:0] p1_addr_u_q, p1_addr_u_d;
    logic [N_LOG-1:0] p1_addr_v_q, p1_addr_v_d;
    logic [DW-1:0]    bf_u_q, bf_u_d;
    logic [DW-1:0]    bf_v_q, bf_v_d;
    logic [DW-1:0]    bf_w_q, bf_w_d;

    logic             wr_en_q, wr_en_d;
    logic [N_LOG-1:0] wr_addr_u_q, wr_addr_u_d;
    logic [N_LOG-1:0] wr_addr_v_q, wr_addr_v_d;
    logic [DW-1:0]    wr_data_u_q, wr_data_u_d;
    logic [DW-1:0]    wr_data_v_q, wr_data_v_d;

    logic [N_LOG-1:0] gen_u, gen_v;
    logic [N_LOG-2:0] gen_tw;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            S_RUN: begin
                if (j_q == J_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else if (stage_q != S_LAST) begin
                    state_d = S_RUN;
                    stage_d = stage_q + 1'b1;
                    j_d     = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are computed for the next issue so rd_addr_* come straight from flops.
    ntt_addr_gen #(
        .N_LOG (N_LOG),
        .SW    (SW)
    ) u_addr_gen (
        .stage (stage_d),
        .j     (j_d),
        .u_idx (gen_u),
        .v_idx (gen_v),
        .tw    (gen_tw)
    );

    assign bf_u = p1_vld_q ? rd_data_u : bf_u_q;
    assign bf_v = p1_vld_q ? rd_data_v : bf_v_q;
    assign bf_w = p1_vld_q ? tw_data   : bf_w_q;

    always_comb begin
        rd_en_d     = (state_d == S_RUN);
        rd_addr_u_d = rd_en_d ? gen_u  : rd_addr_u_q;
        rd_addr_v_d = rd_en_d ? gen_v  : rd_addr_v_q;
        tw_addr_d   = rd_en_d ? gen_tw : tw_addr_q;

        p1_vld_d    = rd_en_q;
        p1_addr_u_d = rd_en_q ? rd_addr_u_q : p1_addr_u_q;
        p1_addr_v_d = rd_en_q ? rd_addr_v_q : p1_addr_v_q;
        bf_u_d      = bf_u;
        bf_v_d      = bf_v;
        bf_w_d      = bf_w;

        wr_en_d     = p1_vld_q;
        wr_addr_u_d = p1_vld_q ? p1_addr_u_q : wr_addr_u_q;
        wr_addr_v_d = p1_vld_q ? p1_addr_v_q : wr_addr_v_q;
        wr_data_u_d = p1_vld_q ? bf_u_out    : wr_data_u_q;
        wr_data_v_d = p1_vld_q ? bf_v_out    : wr_data_v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q     <= 1'b0;
            rd_addr_u_q <= '0;
            rd_addr_v_q <= '0;
            tw_addr_q   <= '0;
            p1_vld_q    <= 1'b0;
            p1_addr_u_q <= '0;
            p1_addr_v_q <= '0;
            bf_u_q      <= '0;
            bf_v_q      <= '0;
            bf_w_q      <= '0;
        end else begin
            rd_en_q     <= rd_en_d;
            rd_addr_u_q <= rd_addr_u_d;
            rd_addr_v_q <= rd_addr_v_d;
            tw_addr_q   <= tw_addr_d;
            p1_vld_q    <= p1_vld_d;
            p1_addr_u_q <= p1_addr_u_d;
            p1_addr_v_q <= p1_addr_v_d;
            bf_u_q      <= bf_u_d;
            bf_v_q      <= bf_v_d;
            bf_w_q      <= bf_w_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_u_q <= '0;
            wr_addr_v_q <= '0;
            wr_data_u_q <= '0;
            wr_data_v_q <= '0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_u_q <= wr_addr_u_d;
            wr_addr_v_q <= wr_addr_v_d;
            wr_data_u_q <= wr_data_u_d;
            wr_data_v_q <= wr_data_v_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rd_en     = rd_en_q;
    assign rd_addr_u = rd_addr_u_q;
    assign rd_addr_v = rd_addr_v_q;
    assign tw_addr   = tw_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr_u = wr_addr_u_q;
    assign wr_addr_v = wr_addr_v_q;
    assign wr_data_u = wr_data_u_q;
    assign wr_data_v = wr_data_v_q;

endmodule
